// File: rtl/event_timestamper_fifo.sv
`default_nettype none
// ============================================================================
// Module   : event_timestamper_fifo
// Purpose  : Per-ID event timestamper. A start event captures the free-running
//            counter for its ID; the matching end event emits a record
//            {id, start, end, delta, status} through a show-ahead output FIFO.
//            A background scanner retires IDs older than cfg_timeout with a
//            TIMEOUT record. Ends with no matching start are counted.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            start_valid/ready/id - start event handshake
//            end_valid/ready/id   - end event handshake
//            cfg_timeout          - age limit in cycles (0 disables)
//            out_valid/ready      - output record handshake (show-ahead)
//            out_id/start_ts/end_ts/delta/status - head record fields
//            inflight_cnt         - number of active IDs
//            err_orphan_cnt       - saturating count of orphan ends
// Revision : 1.0 - initial release
// ============================================================================
module event_timestamper_fifo #(
   parameter int ID_W       = 4,
   parameter int TS_W       = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int TMO_W      = 32,
   parameter int ERR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [ID_W-1:0]   start_id,
   input  logic              end_valid,
   output logic              end_ready,
   input  logic [ID_W-1:0]   end_id,
   input  logic [TMO_W-1:0]  cfg_timeout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   out_id,
   output logic [TS_W-1:0]   out_start_ts,
   output logic [TS_W-1:0]   out_end_ts,
   output logic [TS_W-1:0]   out_delta,
   output logic [1:0]        out_status,
   output logic [ID_W:0]     inflight_cnt,
   output logic [ERR_W-1:0]  err_orphan_cnt
);

   localparam int c_N_IDS = 2**ID_W;
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CMP_W = (TS_W > TMO_W) ? TS_W : TMO_W;
   localparam logic [c_PTR_W+1:0] c_DEPTH  = (c_PTR_W+2)'(FIFO_DEPTH);
   localparam logic [1:0]         c_ST_OK  = 2'b00;
   localparam logic [1:0]         c_ST_TMO = 2'b01;

   // Core state
   logic [TS_W-1:0]    r_cnt;
   logic [c_N_IDS-1:0] r_active;
   logic [TS_W-1:0]    r_ts_mem [c_N_IDS];
   logic [ID_W-1:0]    r_scan_ptr;
   logic [ID_W:0]      r_inflight;
   logic [ERR_W-1:0]   r_err;

   // Single-entry stage between the event logic and the FIFO
   logic               r_stage_valid;
   logic [ID_W-1:0]    r_stage_id;
   logic [TS_W-1:0]    r_stage_start;
   logic [TS_W-1:0]    r_stage_end;
   logic [1:0]         r_stage_status;

   // Output FIFO; pointers carry one extra wrap bit
   logic [ID_W-1:0]    r_fifo_id     [FIFO_DEPTH];
   logic [TS_W-1:0]    r_fifo_start  [FIFO_DEPTH];
   logic [TS_W-1:0]    r_fifo_end    [FIFO_DEPTH];
   logic [1:0]         r_fifo_status [FIFO_DEPTH];
   logic [c_PTR_W:0]   r_wr_ptr;
   logic [c_PTR_W:0]   r_rd_ptr;

   logic [c_PTR_W:0]   w_fifo_count;
   logic               w_space;
   logic               w_pop;
   logic               w_start_fire;
   logic               w_end_fire;
   logic               w_end_hit;
   logic               w_orphan;
   logic [TS_W-1:0]    w_scan_age;
   logic               w_tmo_due;
   logic               w_tmo_fire;
   logic               w_scan_hold;
   logic [c_PTR_W-1:0] w_rd_idx;

   // Room check counts the staged record too, so a record loaded into the
   // stage is always guaranteed a FIFO slot on the following edge.
   assign w_fifo_count = r_wr_ptr - r_rd_ptr;
   assign w_space      = ({1'b0, w_fifo_count} + {{(c_PTR_W+1){1'b0}}, r_stage_valid}) < c_DEPTH;

   // A start on an ID whose end is retiring this same cycle waits one cycle,
   // so the old timestamp is read before being overwritten.
   assign start_ready  = !r_active[start_id] &&
                         !(end_valid && (end_id == start_id) && r_active[end_id]);
   assign end_ready    = r_active[end_id] ? w_space : 1'b1;

   assign w_start_fire = start_valid && start_ready;
   assign w_end_fire   = end_valid && end_ready;
   assign w_end_hit    = w_end_fire && r_active[end_id];
   assign w_orphan     = w_end_fire && !r_active[end_id];

   assign w_scan_age   = r_cnt - r_ts_mem[r_scan_ptr];
   assign w_tmo_due    = (cfg_timeout != '0) && r_active[r_scan_ptr] &&
                         (c_CMP_W'(w_scan_age) >= c_CMP_W'(cfg_timeout));
   // Any end firing owns the stage this cycle, so the scanner yields.
   assign w_tmo_fire   = w_tmo_due && w_space && !w_end_fire;
   // The scanner waits on a due-but-blocked ID unless an end retires it.
   assign w_scan_hold  = w_tmo_due && !w_tmo_fire &&
                         !(w_end_fire && (end_id == r_scan_ptr));

   assign w_rd_idx     = r_rd_ptr[c_PTR_W-1:0];
   assign out_valid    = (w_fifo_count != '0);
   assign w_pop        = out_valid && out_ready;

   // Fields are forced to zero while empty so the port never shows stale data.
   assign out_id       = out_valid ? r_fifo_id[w_rd_idx]     : '0;
   assign out_start_ts = out_valid ? r_fifo_start[w_rd_idx]  : '0;
   assign out_end_ts   = out_valid ? r_fifo_end[w_rd_idx]    : '0;
   assign out_status   = out_valid ? r_fifo_status[w_rd_idx] : '0;
   assign out_delta    = out_end_ts - out_start_ts;

   assign inflight_cnt   = r_inflight;
   assign err_orphan_cnt = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_active   <= '0;
         r_scan_ptr <= '0;
         r_inflight <= '0;
         r_err      <= '0;
      end else begin
         r_cnt <= r_cnt + TS_W'(1);
         // Start, end-hit and timeout always touch distinct IDs.
         if (w_start_fire) r_active[start_id]   <= 1'b1;
         if (w_end_hit)    r_active[end_id]     <= 1'b0;
         if (w_tmo_fire)   r_active[r_scan_ptr] <= 1'b0;
         if (!w_scan_hold) r_scan_ptr <= r_scan_ptr + ID_W'(1);
         case ({w_start_fire, (w_end_hit || w_tmo_fire)})
            2'b10:   r_inflight <= r_inflight + (ID_W+1)'(1);
            2'b01:   r_inflight <= r_inflight - (ID_W+1)'(1);
            default: r_inflight <= r_inflight;
         endcase
         if (w_orphan && (r_err != '1)) r_err <= r_err + ERR_W'(1);
      end
   end

   // Timestamp RAM is intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_start_fire) r_ts_mem[start_id] <= r_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage_valid  <= 1'b0;
         r_stage_id     <= '0;
         r_stage_start  <= '0;
         r_stage_end    <= '0;
         r_stage_status <= c_ST_OK;
      end else begin
         r_stage_valid <= w_end_hit || w_tmo_fire;
         if (w_end_hit) begin
            r_stage_id     <= end_id;
            r_stage_start  <= r_ts_mem[end_id];
            r_stage_end    <= r_cnt;
            r_stage_status <= c_ST_OK;
         end else if (w_tmo_fire) begin
            r_stage_id     <= r_scan_ptr;
            r_stage_start  <= r_ts_mem[r_scan_ptr];
            r_stage_end    <= r_cnt;
            r_stage_status <= c_ST_TMO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_stage_valid) begin
         r_fifo_id[r_wr_ptr[c_PTR_W-1:0]]     <= r_stage_id;
         r_fifo_start[r_wr_ptr[c_PTR_W-1:0]]  <= r_stage_start;
         r_fifo_end[r_wr_ptr[c_PTR_W-1:0]]    <= r_stage_end;
         r_fifo_status[r_wr_ptr[c_PTR_W-1:0]] <= r_stage_status;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (r_stage_valid) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
         if (w_pop)         r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_event_timestamper_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_timestamper_fifo
// Purpose  : Self-checking bench for event_timestamper_fifo. A 64-bit build is
//            checked against a record-level reference model; an 8-bit
//            timestamp / 4-bit error counter build covers wrap and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_timestamper_fifo;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main build (TS_W = 64)
   logic        rst_n, start_valid, start_ready, end_valid, end_ready;
   logic [3:0]  start_id, end_id, out_id;
   logic [31:0] cfg_timeout;
   logic        out_valid, out_ready;
   logic [63:0] out_start_ts, out_end_ts, out_delta;
   logic [1:0]  out_status;
   logic [4:0]  inflight_cnt;
   logic [15:0] err_orphan_cnt;

   // Narrow build (TS_W = 8, ERR_W = 4)
   logic        rst2_n, sv2, sr2, ev2, er2, ov2, or2;
   logic [3:0]  sid2, eid2, oid2;
   logic [31:0] cfg2;
   logic [7:0]  ost2, oet2, odl2;
   logic [1:0]  ostat2;
   logic [4:0]  infl2;
   logic [3:0]  err2;

   event_timestamper_fifo #(.ID_W(4), .TS_W(64), .FIFO_DEPTH(4), .TMO_W(32), .ERR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
      .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
      .cfg_timeout(cfg_timeout),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
      .out_status(out_status), .inflight_cnt(inflight_cnt), .err_orphan_cnt(err_orphan_cnt)
   );

   event_timestamper_fifo #(.ID_W(4), .TS_W(8), .FIFO_DEPTH(4), .TMO_W(32), .ERR_W(4)) dut2 (
      .clk(clk), .rst_n(rst2_n),
      .start_valid(sv2), .start_ready(sr2), .start_id(sid2),
      .end_valid(ev2), .end_ready(er2), .end_id(eid2),
      .cfg_timeout(cfg2),
      .out_valid(ov2), .out_ready(or2), .out_id(oid2),
      .out_start_ts(ost2), .out_end_ts(oet2), .out_delta(odl2),
      .out_status(ostat2), .inflight_cnt(infl2), .err_orphan_cnt(err2)
   );

   typedef struct {
      logic [3:0]  id;
      logic [63:0] st;
      logic [63:0] en;
      logic [63:0] dl;
      logic [1:0]  status;
   } rec_t;

   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference model: which IDs are open, when they opened, and the ordered
   // list of records owed to the consumer.
   logic [63:0] m_cnt;
   bit          m_active [16];
   logic [63:0] m_ts [16];
   rec_t        exp_q [$];
   logic [63:0] m_err;
   bit          loose;
   bit          last_sf, last_ef;
   int          tmo_seen;
   rec_t        last_tmo;
   logic [63:0] tmo_cnt_at;
   int          c2;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      bit exp_sr, exp_er, sf, ef, pop;
      int nact;
      logic [3:0] sid, eid;
      rec_t got, e;
      @(negedge clk);
      sid    = start_id;
      eid    = end_id;
      exp_sr = !m_active[sid] && !(end_valid && (eid == sid) && m_active[eid]);
      exp_er = m_active[eid] ? (exp_q.size() < 4) : 1'b1;
      nact   = 0;
      foreach (m_active[i]) if (m_active[i]) nact++;
      if (!loose) begin
         chk("start_ready", 64'(start_ready), 64'(exp_sr));
         chk("end_ready", 64'(end_ready), 64'(exp_er));
         chk("inflight_cnt", 64'(inflight_cnt), 64'(nact));
      end
      chk("err_orphan_cnt", 64'(err_orphan_cnt), m_err);
      sf  = start_valid && start_ready;
      ef  = end_valid && end_ready;
      pop = out_valid && out_ready;
      if (pop) begin
         got.id = out_id; got.st = out_start_ts; got.en = out_end_ts;
         got.dl = out_delta; got.status = out_status;
         if (loose && got.status == 2'b01) begin
            chk("tmo_id_active", 64'(m_active[got.id]), 64'd1);
            chk("tmo_start", got.st, m_ts[got.id]);
            chk("tmo_delta", got.dl, got.en - got.st);
            chk("tmo_age_min", 64'(got.dl >= 64'(cfg_timeout)), 64'd1);
            chk("tmo_age_max", 64'(got.dl < 64'(cfg_timeout) + 64'd16), 64'd1);
            tmo_seen++;
            last_tmo   = got;
            tmo_cnt_at = m_cnt;
         end else begin
            chk("record_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rec_id", 64'(got.id), 64'(e.id));
               chk("rec_start", got.st, e.st);
               chk("rec_end", got.en, e.en);
               chk("rec_delta", got.dl, e.dl);
               chk("rec_status", 64'(got.status), 64'(e.status));
            end
         end
      end
      @(posedge clk);
      if (pop && loose && got.status == 2'b01) m_active[got.id] = 1'b0;
      if (ef) begin
         if (m_active[eid]) begin
            e.id = eid; e.st = m_ts[eid]; e.en = m_cnt;
            e.dl = m_cnt - m_ts[eid]; e.status = 2'b00;
            exp_q.push_back(e);
            m_active[eid] = 1'b0;
         end else if (m_err != 64'hFFFF) begin
            m_err++;
         end
      end
      if (sf) begin
         m_active[sid] = 1'b1;
         m_ts[sid]     = m_cnt;
      end
      m_cnt++;
      last_sf = sf;
      last_ef = ef;
      #1;
   endtask

   task automatic model_clear();
      foreach (m_active[i]) m_active[i] = 1'b0;
      exp_q.delete();
      m_cnt = 64'd0;
      m_err = 64'd0;
      loose = 1'b0;
   endtask

   task automatic do_reset();
      start_valid = 1'b0; end_valid = 1'b0;
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic end_until_fire(input logic [3:0] id, input string tag);
      int k;
      end_valid = 1'b1; end_id = id; k = 0;
      do begin
         tick();
         k++;
      end while (!last_ef && k < 30);
      chk(tag, 64'(last_ef), 64'd1);
   endtask

   task automatic tick2();
      @(posedge clk);
      #1 c2 = (c2 + 1) % 256;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k;
      rst_n = 1'b0; start_valid = 1'b0; end_valid = 1'b0; start_id = '0; end_id = '0;
      cfg_timeout = '0; out_ready = 1'b0;
      rst2_n = 1'b0; sv2 = 1'b0; ev2 = 1'b0; sid2 = '0; eid2 = '0; cfg2 = '0; or2 = 1'b0;
      model_clear();
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_id", 64'(out_id), 64'd0);
      chk("rst_out_start", out_start_ts, 64'd0);
      chk("rst_out_end", out_end_ts, 64'd0);
      chk("rst_out_delta", out_delta, 64'd0);
      chk("rst_out_status", 64'(out_status), 64'd0);
      chk("rst_inflight", 64'(inflight_cnt), 64'd0);
      chk("rst_err", 64'(err_orphan_cnt), 64'd0);
      chk("rst2_out_valid", 64'(ov2), 64'd0);
      chk("rst2_err", 64'(err2), 64'd0);
      do_reset();

      // Basic pair: start id 3 at cnt 10, end at cnt 25
      out_ready = 1'b1;
      while (m_cnt != 64'd10) tick();
      start_valid = 1'b1; start_id = 4'd3;
      tick();
      chk("t1_start_fire", 64'(last_sf), 64'd1);
      start_valid = 1'b0;
      chk("t1_inflight_1", 64'(inflight_cnt), 64'd1);
      while (m_cnt != 64'd25) tick();
      end_valid = 1'b1; end_id = 4'd3;
      tick();
      chk("t1_end_fire", 64'(last_ef), 64'd1);
      end_valid = 1'b0;
      chk("t1_valid_t1", 64'(out_valid), 64'd0);
      chk("t1_inflight_0", 64'(inflight_cnt), 64'd0);
      tick();
      chk("t1_valid_t2", 64'(out_valid), 64'd1);
      chk("t1_id", 64'(out_id), 64'd3);
      chk("t1_start", out_start_ts, 64'd10);
      chk("t1_end", out_end_ts, 64'd25);
      chk("t1_delta", out_delta, 64'd15);
      chk("t1_status", 64'(out_status), 64'd0);
      tick();
      tick();
      chk("t1_popped", 64'(out_valid), 64'd0);

      // Backpressure: 6 open IDs, FIFO holds 4
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start_valid = 1'b1; start_id = 4'(i);
         tick();
         chk("bp_start_fire", 64'(last_sf), 64'd1);
      end
      start_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         end_valid = 1'b1; end_id = 4'(i);
         tick();
         n += int'(last_ef);
      end
      chk("bp_first4_fired", 64'(n), 64'd4);
      end_id = 4'd4; n = 0;
      repeat (5) begin
         tick();
         n += int'(last_ef);
      end
      chk("bp_5th_blocked", 64'(n), 64'd0);
      chk("bp_end_ready_low", 64'(end_ready), 64'd0);
      chk("bp_head_id", 64'(out_id), 64'd0);
      out_ready = 1'b1;
      end_until_fire(4'd4, "bp_end4_done");
      end_until_fire(4'd5, "bp_end5_done");
      end_valid = 1'b0;
      repeat (12) tick();
      chk("bp_drained", 64'(exp_q.size()), 64'd0);
      chk("bp_out_idle", 64'(out_valid), 64'd0);

      // Same-cycle start and end on an active ID
      start_valid = 1'b1; start_id = 4'd2;
      tick();
      end_valid = 1'b1; end_id = 4'd2;
      tick();
      chk("sc_end_fire", 64'(last_ef), 64'd1);
      chk("sc_start_blocked", 64'(last_sf), 64'd0);
      end_valid = 1'b0;
      tick();
      chk("sc_start_next", 64'(last_sf), 64'd1);
      start_valid = 1'b0;
      repeat (3) tick();
      end_until_fire(4'd2, "sc_end2_done");
      end_valid = 1'b0;
      repeat (4) tick();

      // Orphan end
      end_valid = 1'b1; end_id = 4'd7;
      tick();
      chk("orph_fire", 64'(last_ef), 64'd1);
      end_valid = 1'b0;
      repeat (3) tick();
      chk("orph_cnt", 64'(err_orphan_cnt), 64'd1);
      chk("orph_no_record", 64'(out_valid), 64'd0);

      // Randomized traffic, timeouts disabled
      for (int i = 0; i < 1500; i++) begin
         start_valid = 1'($urandom_range(0, 1));
         start_id    = 4'($urandom_range(0, 15));
         end_valid   = 1'($urandom_range(0, 1));
         end_id      = 4'($urandom_range(0, 15));
         out_ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      start_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) end_until_fire(4'(i), "rnd_close");
      end_valid = 1'b0;
      repeat (10) tick();
      chk("rnd_drained", 64'(exp_q.size()), 64'd0);
      chk("rnd_idle", 64'(out_valid), 64'd0);
      chk("rnd_inflight", 64'(inflight_cnt), 64'd0);

      // Timeout: cfg 100, id 9 started at cnt 0
      cfg_timeout = 32'd100;
      do_reset();
      start_valid = 1'b1; start_id = 4'd9;
      tick();
      start_valid = 1'b0;
      loose = 1'b1; out_ready = 1'b1; tmo_seen = 0; k = 0;
      while (tmo_seen == 0 && k < 200) begin
         tick();
         k++;
      end
      chk("tmo_seen", 64'(tmo_seen), 64'd1);
      chk("tmo_rec_id", 64'(last_tmo.id), 64'd9);
      chk("tmo_rec_start", last_tmo.st, 64'd0);
      chk("tmo_latency", 64'(tmo_cnt_at <= 64'd118), 64'd1);
      loose = 1'b0;
      chk("tmo_inflight", 64'(inflight_cnt), 64'd0);
      end_valid = 1'b1; end_id = 4'd9;
      tick();
      end_valid = 1'b0;
      tick();
      chk("tmo_late_end_orphan", 64'(err_orphan_cnt), 64'd1);
      cfg_timeout = 32'd0;
      start_valid = 1'b1; start_id = 4'd5;
      tick();
      start_valid = 1'b0;
      repeat (300) tick();
      chk("tmo_disabled_no_rec", 64'(out_valid), 64'd0);
      chk("tmo_disabled_active", 64'(inflight_cnt), 64'd1);

      // Reset while records are queued
      out_ready = 1'b0;
      end_until_fire(4'd5, "mr_end5");
      start_valid = 1'b1; start_id = 4'd1;
      tick();
      start_valid = 1'b0; end_valid = 1'b0;
      repeat (3) tick();
      chk("mr_queued", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_inflight", 64'(inflight_cnt), 64'd0);
      chk("mr_out_id", 64'(out_id), 64'd0);
      do_reset();
      out_ready = 1'b1;
      repeat (4) tick();
      chk("mr_after_idle", 64'(out_valid), 64'd0);

      // Narrow build: wrap, mid-queue reset, saturation
      @(posedge clk);
      #1 rst2_n = 1'b1; c2 = 0;
      while (c2 != 251) tick2();
      sv2 = 1'b1; sid2 = 4'd1;
      tick2();
      chk("w_start_ready", 64'(sr2), 64'd0);
      sv2 = 1'b0;
      while (c2 != 4) tick2();
      ev2 = 1'b1; eid2 = 4'd1;
      tick2();
      ev2 = 1'b0;
      chk("w_valid_t1", 64'(ov2), 64'd0);
      tick2();
      chk("w_valid_t2", 64'(ov2), 64'd1);
      chk("w_id", 64'(oid2), 64'd1);
      chk("w_start", 64'(ost2), 64'd251);
      chk("w_end", 64'(oet2), 64'd4);
      chk("w_delta", 64'(odl2), 64'd9);
      chk("w_status", 64'(ostat2), 64'd0);
      for (int i = 2; i < 5; i++) begin
         sv2 = 1'b1; sid2 = 4'(i);
         tick2();
      end
      sv2 = 1'b0;
      ev2 = 1'b1; eid2 = 4'd2; tick2();
      eid2 = 4'd3; tick2();
      ev2 = 1'b0;
      tick2(); tick2();
      chk("w_inflight_pre", 64'(infl2), 64'd1);
      chk("w_queued", 64'(ov2), 64'd1);
      #2 rst2_n = 1'b0;
      #1;
      chk("w_rst_valid", 64'(ov2), 64'd0);
      chk("w_rst_inflight", 64'(infl2), 64'd0);
      @(posedge clk);
      #1 rst2_n = 1'b1;
      ev2 = 1'b1; eid2 = 4'd6;
      repeat (14) tick2();
      chk("w_orph_14", 64'(err2), 64'd14);
      repeat (6) tick2();
      chk("w_orph_sat", 64'(err2), 64'd15);
      ev2 = 1'b0;
      tick2();
      chk("w_orph_no_rec", 64'(ov2), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
